// File: rtl/if_stage_pkg.sv
// Shared constants and bus layouts for the instruction-fetch / decode boundary.
package if_stage_pkg;
  localparam int          FS_TO_DS_BUS_WD = 64;
  localparam int          BR_BUS_WD       = 33;
  localparam logic [31:0] RESET_PC        = 32'h1c00_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;
endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, fetch request to a synchronous SRAM,
// and a one-entry buffer that holds the returned word while decode stalls.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = if_stage_pkg::RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  output logic                       inst_sram_en,
  output logic                       inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);

  logic        fs_valid;
  logic        buf_valid;
  logic        fs_allowin;
  logic [31:0] fs_pc;
  logic [31:0] inst_buf;
  logic [31:0] fs_inst;
  logic [31:0] nextpc;
  logic [31:0] br_aligned;
  fs_to_ds_t   fs_bus;

  assign br_aligned = br_target & 32'hffff_fffc;
  assign nextpc     = br_taken ? br_aligned : fs_pc + 32'd4;
  assign fs_allowin = ~fs_valid | (ds_allowin & fs_valid) | br_taken;

  assign inst_sram_en    = ~reset & fs_allowin;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
    end else if (fs_allowin) begin
      fs_valid <= 1'b1;
      fs_pc    <= nextpc;
    end
  end

  // The SRAM word is only valid for one cycle, so park it on the first stall
  // cycle; a redirect or handshake frees the slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      inst_buf  <= 32'h0;
    end else if (br_taken || (fs_to_ds_valid && ds_allowin)) begin
      buf_valid <= 1'b0;
    end else if (fs_valid && !ds_allowin && !buf_valid) begin
      buf_valid <= 1'b1;
      inst_buf  <= inst_sram_rdata;
    end
  end

  assign fs_inst        = buf_valid ? inst_buf : (reset ? 32'h0 : inst_sram_rdata);
  assign fs_to_ds_valid = fs_valid & ~br_taken;
  assign fs_bus         = '{inst: fs_inst, pc: fs_pc};
  assign fs_to_ds_bus   = fs_bus;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: SRAM model returns pc-tagged words, and
// expected deliveries are queued per scenario and popped on each handshake.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ds_allowin = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        inst_sram_en, inst_sram_we;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        rnd = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_bus;

  if_stage dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_taken(br_taken),
    .br_target(br_target), .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata), .fs_to_ds_valid(fs_to_ds_valid),
    .fs_to_ds_bus(fs_to_ds_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hdead_beef;
  endfunction

  // synchronous SRAM; when idle and rnd is set, scramble the read port
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_of(inst_sram_addr);
    else if (rnd)     inst_sram_rdata <= $urandom;
  end

  task automatic do_reset();
    reset = 1'b1; ds_allowin = 1'b0; br_taken = 1'b0; rnd = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; rnd = 1'b1; ds_allowin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", inst_sram_en); end
    n_chk++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", fs_to_ds_valid); end
    n_chk++; if (fs_to_ds_bus !== {32'h0, 32'h1bff_fffc}) begin n_fail++; $display("FAIL reset_bus got %h want %h", fs_to_ds_bus, {32'h0, 32'h1bff_fffc}); end
    n_chk++; if (inst_sram_we !== 1'b0 || inst_sram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_we_wdata got %b/%h want 0/0", inst_sram_we, inst_sram_wdata); end
    @(posedge clk); #1 reset = 1'b0; rnd = 1'b0;
    @(negedge clk);
    n_chk++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0000) begin n_fail++; $display("FAIL first_fetch got en=%b addr=%h want en=1 addr=1c000000", inst_sram_en, inst_sram_addr); end
  endtask

  task automatic test_seq_stall();
    logic        ds [7] = '{1,1,1,0,0,0,1};
    logic        en [7] = '{1,1,1,0,0,0,1};
    logic [31:0] ad [7] = '{32'h1c000000, 32'h1c000004, 32'h1c000008, 0, 0, 0, 32'h1c00000c};
    do_reset();
    sb.push_back({inst_of(32'h1c000000), 32'h1c000000});
    sb.push_back({inst_of(32'h1c000004), 32'h1c000004});
    sb.push_back({inst_of(32'h1c000008), 32'h1c000008});
    for (int c = 0; c < 7; c++) begin
      ds_allowin = ds[c]; rnd = (c >= 3);
      @(negedge clk);
      n_chk++; if (inst_sram_en !== en[c]) begin n_fail++; $display("FAIL seq_en c%0d got %b want %b", c, inst_sram_en, en[c]); end
      if (en[c]) begin
        n_chk++; if (inst_sram_addr !== ad[c]) begin n_fail++; $display("FAIL seq_addr c%0d got %h want %h", c, inst_sram_addr, ad[c]); end
      end
      if (c >= 3 && c <= 5) begin
        n_chk++; if (fs_to_ds_bus !== {inst_of(32'h1c000008), 32'h1c000008}) begin n_fail++; $display("FAIL stall_hold c%0d got %h want %h", c, fs_to_ds_bus, {inst_of(32'h1c000008), 32'h1c000008}); end
      end
      if (fs_to_ds_valid && ds_allowin) begin
        n_chk++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL seq_extra c%0d got %h want none", c, fs_to_ds_bus); end
        else begin exp_bus = sb.pop_front(); if (fs_to_ds_bus !== exp_bus) begin n_fail++; $display("FAIL seq_bus c%0d got %h want %h", c, fs_to_ds_bus, exp_bus); end end
      end
      @(posedge clk); #1;
    end
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL seq_missing got %0d left want 0", sb.size()); end
  endtask

  task automatic test_branch();
    logic        br [4] = '{0,0,1,0};
    logic [31:0] ad [4] = '{32'h1c000000, 32'h1c000004, 32'h1c000100, 32'h1c000104};
    do_reset();
    sb.push_back({inst_of(32'h1c000000), 32'h1c000000});
    sb.push_back({inst_of(32'h1c000100), 32'h1c000100});
    for (int c = 0; c < 4; c++) begin
      ds_allowin = 1'b1; br_taken = br[c]; br_target = 32'h1c000100;
      @(negedge clk);
      n_chk++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== ad[c]) begin n_fail++; $display("FAIL br_addr c%0d got en=%b %h want en=1 %h", c, inst_sram_en, inst_sram_addr, ad[c]); end
      if (br[c]) begin
        n_chk++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL br_kill c%0d got %b want 0", c, fs_to_ds_valid); end
      end
      if (fs_to_ds_valid && ds_allowin) begin
        n_chk++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL br_extra c%0d got %h want none", c, fs_to_ds_bus); end
        else begin exp_bus = sb.pop_front(); if (fs_to_ds_bus !== exp_bus) begin n_fail++; $display("FAIL br_bus c%0d got %h want %h", c, fs_to_ds_bus, exp_bus); end end
      end
      @(posedge clk); #1;
    end
    br_taken = 1'b0;
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL br_missing got %0d left want 0", sb.size()); end
  endtask

  task automatic test_branch_in_stall();
    logic        ds [6] = '{1,1,0,0,0,1};
    logic        br [6] = '{0,0,0,0,1,0};
    logic        en [6] = '{1,1,0,0,1,1};
    logic [31:0] ad [6] = '{32'h1c000000, 32'h1c000004, 0, 0, 32'h1c000200, 32'h1c000204};
    do_reset();
    sb.push_back({inst_of(32'h1c000000), 32'h1c000000});
    sb.push_back({inst_of(32'h1c000200), 32'h1c000200});
    for (int c = 0; c < 6; c++) begin
      ds_allowin = ds[c]; br_taken = br[c]; br_target = 32'h1c000200; rnd = (c >= 2);
      @(negedge clk);
      n_chk++; if (inst_sram_en !== en[c]) begin n_fail++; $display("FAIL bst_en c%0d got %b want %b", c, inst_sram_en, en[c]); end
      if (en[c]) begin
        n_chk++; if (inst_sram_addr !== ad[c]) begin n_fail++; $display("FAIL bst_addr c%0d got %h want %h", c, inst_sram_addr, ad[c]); end
      end
      if (fs_to_ds_valid && ds_allowin) begin
        n_chk++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL bst_extra c%0d got %h want none", c, fs_to_ds_bus); end
        else begin exp_bus = sb.pop_front(); if (fs_to_ds_bus !== exp_bus) begin n_fail++; $display("FAIL bst_bus c%0d got %h want %h", c, fs_to_ds_bus, exp_bus); end end
      end
      @(posedge clk); #1;
    end
    br_taken = 1'b0;
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL bst_missing got %0d left want 0", sb.size()); end
  endtask

  task automatic test_align_wrap();
    logic        br [5] = '{0,1,0,1,0};
    logic [31:0] tg [5] = '{0, 32'h1c000103, 0, 32'hffffffff, 0};
    logic [31:0] ad [5] = '{32'h1c000000, 32'h1c000100, 32'h1c000104, 32'hfffffffc, 32'h00000000};
    do_reset();
    sb.push_back({inst_of(32'h1c000100), 32'h1c000100});
    sb.push_back({inst_of(32'hfffffffc), 32'hfffffffc});
    for (int c = 0; c < 5; c++) begin
      ds_allowin = 1'b1; br_taken = br[c]; br_target = tg[c];
      @(negedge clk);
      n_chk++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== ad[c]) begin n_fail++; $display("FAIL aw_addr c%0d got en=%b %h want en=1 %h", c, inst_sram_en, inst_sram_addr, ad[c]); end
      if (fs_to_ds_valid && ds_allowin) begin
        n_chk++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL aw_extra c%0d got %h want none", c, fs_to_ds_bus); end
        else begin exp_bus = sb.pop_front(); if (fs_to_ds_bus !== exp_bus) begin n_fail++; $display("FAIL aw_bus c%0d got %h want %h", c, fs_to_ds_bus, exp_bus); end end
      end
      @(posedge clk); #1;
    end
    br_taken = 1'b0;
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL aw_missing got %0d left want 0", sb.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    rnd = 1'b1; ds_allowin = 1'b1;
    repeat (2) @(posedge clk);
    #1 ds_allowin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (fs_to_ds_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre got %b want 1", fs_to_ds_valid); end
    #2 reset = 1'b1;
    #1;
    n_chk++; if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL ar_drop got valid=%b en=%b want 0/0", fs_to_ds_valid, inst_sram_en); end
    n_chk++; if (fs_to_ds_bus !== {32'h0, 32'h1bff_fffc}) begin n_fail++; $display("FAIL ar_bus got %h want %h", fs_to_ds_bus, {32'h0, 32'h1bff_fffc}); end
    @(posedge clk); #1 reset = 1'b0; ds_allowin = 1'b1;
    sb.delete();
    sb.push_back({inst_of(32'h1c000000), 32'h1c000000});
    @(negedge clk);
    n_chk++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000000) begin n_fail++; $display("FAIL ar_restart got en=%b %h want en=1 1c000000", inst_sram_en, inst_sram_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (!(fs_to_ds_valid && ds_allowin)) begin n_fail++; $display("FAIL ar_deliver got valid=%b want 1", fs_to_ds_valid); end
    else begin exp_bus = sb.pop_front(); if (fs_to_ds_bus !== exp_bus) begin n_fail++; $display("FAIL ar_bus2 got %h want %h", fs_to_ds_bus, exp_bus); end end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    test_reset();
    test_seq_stall();
    test_branch();
    test_branch_in_stall();
    test_align_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h1c000000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ds_allowin  input  1  decode stage can accept an instruction this cycle.
REQ-005 br_taken  input  1  redirect request from decode; asserted only in the cycle the branch leaves decode.
REQ-006 br_target  input  32  redirect address, valid when br_taken=1.
REQ-007 inst_sram_en  output  1  fetch request enable.
REQ-008 inst_sram_we  output  1  constant 0.
REQ-009 inst_sram_addr  output  32  fetch address.
REQ-010 inst_sram_wdata  output  32  constant 0.
REQ-011 inst_sram_rdata  input  32  instruction word; synchronous SRAM, valid the cycle after the request.
REQ-012 fs_to_ds_valid  output  1  fs_to_ds_bus holds a valid instruction.
REQ-013 fs_to_ds_bus  output  64  {fs_inst[63:32], fs_pc[31:0]}.

Function
REQ-014 nextpc SHALL be br_taken ? {br_target[31:2],2'b00} : fs_pc+4, in 32-bit wrap-around arithmetic.
REQ-015 fs_allowin SHALL be ~fs_valid | (ds_allowin & fs_valid) | br_taken.
REQ-016 inst_sram_en SHALL be ~reset & fs_allowin, and inst_sram_addr SHALL be nextpc.
REQ-017 When inst_sram_en=1, the next edge SHALL set fs_valid=1 and fs_pc=nextpc.
REQ-018 When inst_sram_en=0, fs_valid and fs_pc SHALL hold.
REQ-019 fs_to_ds_valid SHALL be fs_valid & ~br_taken.
REQ-020 Fetch latency: an address presented in cycle N SHALL appear on fs_to_ds_bus with fs_to_ds_valid=1 in cycle N+1.
REQ-021 A handshake occurs when fs_to_ds_valid & ds_allowin; each fetched instruction SHALL be delivered exactly once.
REQ-022 Stall: on the first cycle with fs_valid=1, ds_allowin=0, br_taken=0 and buf_valid=0, the next edge SHALL capture inst_sram_rdata into inst_buf and set buf_valid=1.
REQ-023 fs_inst SHALL be buf_valid ? inst_buf : inst_sram_rdata.
REQ-024 buf_valid SHALL clear on a handshake or on br_taken.
REQ-025 Redirect: while br_taken=1, the instruction held in IF SHALL be discarded, and the request at br_target SHALL be issued in the same cycle regardless of ds_allowin.
REQ-026 If br_taken coincides with a stall, the redirect SHALL take precedence: the buffer clears and the new fetch issues.
REQ-027 A multi-cycle stall SHALL keep fs_pc and fs_inst bit-stable, with no new SRAM request.

Reset
REQ-028 Asynchronous reset assertion SHALL immediately force fs_pc=RESET_PC-4, fs_valid=0, buf_valid=0 and inst_buf=0.
REQ-029 During reset: inst_sram_en=0 and fs_to_ds_valid=0; fs_to_ds_bus is {32'h0, RESET_PC-4}.
REQ-030 In the first cycle after reset deassertion, inst_sram_en=1 with inst_sram_addr=RESET_PC.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state.

Structure
REQ-032 A shared package SHALL hold the constants FS_TO_DS_BUS_WD=64, BR_BUS_WD=33 and RESET_PC, for reuse by the decode stage.
REQ-033 The block SHALL be a single module with no sub-module; the PC register, valid bit and instruction buffer are inline.

Verification
REQ-034 Reset release, ds_allowin=1, SRAM returns pc-tagged words -> addresses 1c000000, 1c000004, 1c000008 on consecutive cycles; the bus shows the matching pc/inst one cycle later.
REQ-035 Stall of 3 cycles while fs_pc=1c000008 -> inst_sram_en=0 for 3 cycles; the bus holds the 1c000008 word even if rdata is randomised; delivered once when ds_allowin rises.
REQ-036 br_taken=1, br_target=1c000100 while IF holds 1c000004 -> 1c000004 is never handshaken; addr=1c000100 that cycle; the next bus pc is 1c000100.
REQ-037 br_taken during a stall, with buffer full -> buffer discarded; the next delivered pc equals br_target.
REQ-038 br_target=1c000103 -> inst_sram_addr=1c000100; fs_pc=FFFFFFFC sequential -> next addr 00000000.
REQ-039 Reset asserted asynchronously mid-cycle during a stall -> fs_to_ds_valid drops without a clock edge; after release the fetch restarts at 1c000000.
